rs_alu_queue: RTL and testbench

Reservation station for the integer ALU pipe. It sits directly downstream of the dispatch-stage operand select / forwarding logic and captures each dispatched instruction together with its resolved-or-tagged operands. Resident entries wake up on the two result-broadcast buses, and the oldest fully ready entry issues to the ALU through a valid/ready handshake.

---
 rtl/rs_alu_queue_pkg.sv | 21 ++
 rtl/rs_alu_queue_if.sv | 61 ++++++
 rtl/rs_alu_queue_oldest.sv | 22 ++
 rtl/rs_alu_queue.sv | 147 ++++++++++++++
 tb/tb_rs_alu_queue.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/rs_alu_queue_pkg.sv
// rs_alu_queue shared constants and the per-slot payload bundle.
// Widths here are common to every reservation station in the core.
package rs_alu_queue_pkg;

  localparam int DATA_LEN        = 32;
  localparam int ADDR_LEN        = 32;
  localparam int PRF_SEL         = 6;
  localparam int ALU_OP_WIDTH    = 4;
  localparam int SRC_A_SEL_WIDTH = 2;
  localparam int SRC_B_SEL_WIDTH = 2;

  typedef struct packed {
    logic [DATA_LEN-1:0]        imm;
    logic [ADDR_LEN-1:0]        pc;
    logic [PRF_SEL-1:0]         rrftag;
    logic [ALU_OP_WIDTH-1:0]    alu_op;
    logic [SRC_A_SEL_WIDTH-1:0] src_a_sel;
    logic [SRC_B_SEL_WIDTH-1:0] src_b_sel;
  } rs_ent_t;

endpackage

// File: rtl/rs_alu_queue_if.sv
// rs_alu_queue bus: dispatch, wakeup broadcasts and ALU issue.
// master drives dispatch/wakeup/ready, slave is the station.
interface rs_alu_queue_if #(parameter int ENTRIES = 4);
  import rs_alu_queue_pkg::*;

  localparam int CW = $clog2(ENTRIES) + 1;

  logic                       flush;
  logic                       dp_we;
  logic [DATA_LEN-1:0]        dp_src1;
  logic [DATA_LEN-1:0]        dp_src2;
  logic                       dp_rdy1;
  logic                       dp_rdy2;
  logic [DATA_LEN-1:0]        dp_imm;
  logic [ADDR_LEN-1:0]        dp_pc;
  logic [PRF_SEL-1:0]         dp_rrftag;
  logic [ALU_OP_WIDTH-1:0]    dp_alu_op;
  logic [SRC_A_SEL_WIDTH-1:0] dp_src_a_sel;
  logic [SRC_B_SEL_WIDTH-1:0] dp_src_b_sel;
  logic                       wk_we1;
  logic [PRF_SEL-1:0]         wk_ent1;
  logic [DATA_LEN-1:0]        wk_data1;
  logic                       wk_we2;
  logic [PRF_SEL-1:0]         wk_ent2;
  logic [DATA_LEN-1:0]        wk_data2;
  logic                       iss_valid;
  logic                       iss_ready;
  logic [DATA_LEN-1:0]        iss_src1;
  logic [DATA_LEN-1:0]        iss_src2;
  logic [DATA_LEN-1:0]        iss_imm;
  logic [ADDR_LEN-1:0]        iss_pc;
  logic [PRF_SEL-1:0]         iss_rrftag;
  logic [ALU_OP_WIDTH-1:0]    iss_alu_op;
  logic [SRC_A_SEL_WIDTH-1:0] iss_src_a_sel;
  logic [SRC_B_SEL_WIDTH-1:0] iss_src_b_sel;
  logic                       full;
  logic [CW-1:0]              count;

  modport master (
    output flush, dp_we, dp_src1, dp_src2, dp_rdy1, dp_rdy2,
    output dp_imm, dp_pc, dp_rrftag, dp_alu_op,
    output dp_src_a_sel, dp_src_b_sel,
    output wk_we1, wk_ent1, wk_data1, wk_we2, wk_ent2, wk_data2,
    output iss_ready,
    input  iss_valid, iss_src1, iss_src2, iss_imm, iss_pc,
    input  iss_rrftag, iss_alu_op, iss_src_a_sel, iss_src_b_sel,
    input  full, count
  );

  modport slave (
    input  flush, dp_we, dp_src1, dp_src2, dp_rdy1, dp_rdy2,
    input  dp_imm, dp_pc, dp_rrftag, dp_alu_op,
    input  dp_src_a_sel, dp_src_b_sel,
    input  wk_we1, wk_ent1, wk_data1, wk_we2, wk_ent2, wk_data2,
    input  iss_ready,
    output iss_valid, iss_src1, iss_src2, iss_imm, iss_pc,
    output iss_rrftag, iss_alu_op, iss_src_a_sel, iss_src_b_sel,
    output full, count
  );

endinterface

// File: rtl/rs_alu_queue_oldest.sv
// Oldest-first selector over an age matrix (row i bit j = j older).
// Shared by the ALU, LSU and branch stations.
module rs_oldest_select #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_elig,
  input  logic [N-1:0][N-1:0]  i_age,
  output logic [N-1:0]         o_grant,
  output logic                 o_valid
);

  // grant the eligible slot with no older eligible slot
  always_comb begin
    o_grant = '0;
    for (int i = 0; i < N; i++) begin
      o_grant[i] = i_elig[i] & ~|(i_age[i] & i_elig);
    end
  end

  assign o_valid = |o_grant;

endmodule

// File: rtl/rs_alu_queue.sv
// Integer ALU reservation station: capture, wakeup, oldest-ready issue.
// Age rows track relative order so issue stays oldest-first.
module rs_alu_queue
  import rs_alu_queue_pkg::*;
#(
  parameter int ENTRIES = 4
) (
  input  logic          clk,
  input  logic          reset,
  rs_alu_queue_if.slave io
);

  localparam int CW = $clog2(ENTRIES) + 1;

  logic [ENTRIES-1:0]               r_busy;
  logic [ENTRIES-1:0]               r_rdy1;
  logic [ENTRIES-1:0]               r_rdy2;
  logic [DATA_LEN-1:0]              r_src1 [ENTRIES];
  logic [DATA_LEN-1:0]              r_src2 [ENTRIES];
  rs_ent_t                          r_ent  [ENTRIES];
  logic [ENTRIES-1:0][ENTRIES-1:0]  r_age;

  logic [ENTRIES-1:0]  w_elig;
  logic [ENTRIES-1:0]  w_grant;
  logic [ENTRIES-1:0]  w_free;
  logic [ENTRIES-1:0]  w_clr;
  logic                w_sel_v;
  logic                w_fire;
  logic                w_full;
  logic                w_dp;
  logic [CW-1:0]       w_cnt;
  rs_ent_t             w_dp_ent;
  rs_ent_t             w_iss_ent;
  logic [DATA_LEN-1:0] w_iss_src1;
  logic [DATA_LEN-1:0] w_iss_src2;

  assign w_elig = r_busy & r_rdy1 & r_rdy2;

  rs_oldest_select #(.N(ENTRIES)) u_sel (
    .i_elig  (w_elig),
    .i_age   (r_age),
    .o_grant (w_grant),
    .o_valid (w_sel_v)
  );

  assign w_fire = w_sel_v & io.iss_ready;
  assign w_clr  = w_fire ? w_grant : '0;
  assign w_full = &r_busy;
  assign w_dp   = io.dp_we & ~w_full & ~io.flush;
  // lowest clear bit of r_busy, as one-hot
  assign w_free = ~r_busy & (r_busy + ENTRIES'(1));

  assign w_dp_ent = '{
    imm:       io.dp_imm,
    pc:        io.dp_pc,
    rrftag:    io.dp_rrftag,
    alu_op:    io.dp_alu_op,
    src_a_sel: io.dp_src_a_sel,
    src_b_sel: io.dp_src_b_sel
  };

  // occupancy count from busy bits
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_cnt = w_cnt + CW'(r_busy[i]);
    end
  end

  // one-hot mux of the granted slot onto the issue port
  always_comb begin
    w_iss_ent  = '0;
    w_iss_src1 = '0;
    w_iss_src2 = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (w_grant[i]) begin
        w_iss_ent  = r_ent[i];
        w_iss_src1 = r_src1[i];
        w_iss_src2 = r_src2[i];
      end
    end
  end

  // slot state: flush, issue free, dispatch write, operand wakeup
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
      r_rdy1 <= '0;
      r_rdy2 <= '0;
      r_age  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_src1[i] <= '0;
        r_src2[i] <= '0;
        r_ent[i]  <= '0;
      end
    end else if (io.flush) begin
      r_busy <= '0;
      r_age  <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_age[i] <= r_age[i] & ~w_clr;
        if (w_clr[i]) r_busy[i] <= 1'b0;
        if (w_dp && w_free[i]) begin
          r_busy[i] <= 1'b1;
          r_rdy1[i] <= io.dp_rdy1;
          r_rdy2[i] <= io.dp_rdy2;
          r_src1[i] <= io.dp_src1;
          r_src2[i] <= io.dp_src2;
          r_ent[i]  <= w_dp_ent;
          r_age[i]  <= r_busy & ~w_clr;
        end else if (r_busy[i]) begin
          if (!r_rdy1[i]) begin
            if (io.wk_we1 && r_src1[i][PRF_SEL-1:0] == io.wk_ent1) begin
              r_src1[i] <= io.wk_data1;
              r_rdy1[i] <= 1'b1;
            end else if (io.wk_we2 && r_src1[i][PRF_SEL-1:0] == io.wk_ent2) begin
              r_src1[i] <= io.wk_data2;
              r_rdy1[i] <= 1'b1;
            end
          end
          if (!r_rdy2[i]) begin
            if (io.wk_we1 && r_src2[i][PRF_SEL-1:0] == io.wk_ent1) begin
              r_src2[i] <= io.wk_data1;
              r_rdy2[i] <= 1'b1;
            end else if (io.wk_we2 && r_src2[i][PRF_SEL-1:0] == io.wk_ent2) begin
              r_src2[i] <= io.wk_data2;
              r_rdy2[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign io.iss_valid     = w_sel_v;
  assign io.iss_src1      = w_iss_src1;
  assign io.iss_src2      = w_iss_src2;
  assign io.iss_imm       = w_iss_ent.imm;
  assign io.iss_pc        = w_iss_ent.pc;
  assign io.iss_rrftag    = w_iss_ent.rrftag;
  assign io.iss_alu_op    = w_iss_ent.alu_op;
  assign io.iss_src_a_sel = w_iss_ent.src_a_sel;
  assign io.iss_src_b_sel = w_iss_ent.src_b_sel;
  assign io.full          = w_full;
  assign io.count         = w_cnt;

endmodule

// File: tb/tb_rs_alu_queue.sv
// Directed self-checking bench for rs_alu_queue (ENTRIES=4).
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_rs_alu_queue;
  import rs_alu_queue_pkg::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   fails  = 0;

  rs_alu_queue_if #(.ENTRIES(4)) bus ();

  rs_alu_queue #(.ENTRIES(4)) dut (
    .clk   (clk),
    .reset (rst_n),
    .io    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush   = 1'b0;
    bus.dp_we   = 1'b0;
    bus.wk_we1  = 1'b0;
    bus.wk_we2  = 1'b0;
  endtask

  task automatic dp(input logic [5:0] tag,
                    input logic [31:0] s1, input logic r1,
                    input logic [31:0] s2, input logic r2);
    bus.dp_we        = 1'b1;
    bus.dp_rrftag    = tag;
    bus.dp_src1      = s1;
    bus.dp_rdy1      = r1;
    bus.dp_src2      = s2;
    bus.dp_rdy2      = r2;
    bus.dp_imm       = 32'h100 + 32'(tag);
    bus.dp_pc        = 32'h4000 + 32'(tag);
    bus.dp_alu_op    = tag[3:0];
    bus.dp_src_a_sel = tag[1:0];
    bus.dp_src_b_sel = 2'd1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    bus.iss_ready = 1'b0;
    bus.dp_src1 = '0; bus.dp_src2 = '0;
    bus.dp_rdy1 = 1'b0; bus.dp_rdy2 = 1'b0;
    bus.dp_imm = '0; bus.dp_pc = '0; bus.dp_rrftag = '0;
    bus.dp_alu_op = '0; bus.dp_src_a_sel = '0; bus.dp_src_b_sel = '0;
    bus.wk_ent1 = '0; bus.wk_data1 = '0;
    bus.wk_ent2 = '0; bus.wk_data2 = '0;
    repeat (2) step();
    chk("rst_valid", 64'(bus.iss_valid), 64'd0);
    chk("rst_full",  64'(bus.full),      64'd0);
    chk("rst_count", 64'(bus.count),     64'd0);
    rst_n = 1'b1;

    // single ready dispatch, issue next cycle
    bus.iss_ready = 1'b1;
    dp(6'd9, 32'd5, 1'b1, 32'd7, 1'b1);
    step();
    idle();
    chk("t1_count1", 64'(bus.count),      64'd1);
    chk("t1_valid",  64'(bus.iss_valid),  64'd1);
    chk("t1_src1",   64'(bus.iss_src1),   64'd5);
    chk("t1_src2",   64'(bus.iss_src2),   64'd7);
    chk("t1_tag",    64'(bus.iss_rrftag), 64'd9);
    chk("t1_imm",    64'(bus.iss_imm),    64'h109);
    chk("t1_pc",     64'(bus.iss_pc),     64'h4009);
    step();
    chk("t1_count0", 64'(bus.count),      64'd0);
    chk("t1_valid0", 64'(bus.iss_valid),  64'd0);

    // src2 waits on tag 0x12, woken by bus 2
    dp(6'd10, 32'd3, 1'b1, 32'h12, 1'b0);
    step();
    idle();
    chk("t2_wait_a", 64'(bus.iss_valid), 64'd0);
    chk("t2_cnt",    64'(bus.count),     64'd1);
    step();
    chk("t2_wait_b", 64'(bus.iss_valid), 64'd0);
    bus.wk_we2 = 1'b1; bus.wk_ent2 = 6'h12; bus.wk_data2 = 32'hDEAD;
    step();
    idle();
    chk("t2_valid",  64'(bus.iss_valid), 64'd1);
    chk("t2_src2",   64'(bus.iss_src2),  64'hDEAD);
    chk("t2_src1",   64'(bus.iss_src1),  64'd3);
    step();
    chk("t2_cnt0",   64'(bus.count),     64'd0);

    // fill, drop 5th, drain in order
    bus.iss_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      dp(6'(k), 32'(k), 1'b1, 32'd0, 1'b1);
      step();
    end
    chk("t3_full",  64'(bus.full),  64'd1);
    chk("t3_cnt4",  64'(bus.count), 64'd4);
    dp(6'd5, 32'd5, 1'b1, 32'd0, 1'b1);
    step();
    idle();
    chk("t3_drop",  64'(bus.count), 64'd4);
    bus.iss_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("t3_order%0d", k), 64'(bus.iss_rrftag), 64'(k));
      step();
    end
    chk("t3_empty", 64'(bus.iss_valid), 64'd0);
    chk("t3_cnt0",  64'(bus.count),     64'd0);

    // A waits, B ready: B first; A then beats later C
    bus.iss_ready = 1'b0;
    dp(6'd20, 32'h05, 1'b0, 32'd1, 1'b1);
    step();
    dp(6'd21, 32'd2, 1'b1, 32'd2, 1'b1);
    step();
    idle();
    chk("t4_b_first", 64'(bus.iss_rrftag), 64'd21);
    bus.wk_we1 = 1'b1; bus.wk_ent1 = 6'h05; bus.wk_data1 = 32'hAA;
    step();
    idle();
    chk("t4_a_old",  64'(bus.iss_rrftag), 64'd20);
    chk("t4_a_src1", 64'(bus.iss_src1),   64'hAA);
    bus.iss_ready = 1'b1;
    dp(6'd22, 32'd3, 1'b1, 32'd3, 1'b1);
    step();
    idle();
    chk("t4_cnt_same", 64'(bus.count),      64'd2);
    chk("t4_b_next",   64'(bus.iss_rrftag), 64'd21);
    step();
    chk("t4_c_last",   64'(bus.iss_rrftag), 64'd22);
    step();
    chk("t4_cnt0",     64'(bus.count),      64'd0);

    // both buses hit the same tag: bus 1 wins
    bus.iss_ready = 1'b0;
    dp(6'd30, 32'h07, 1'b0, 32'd2, 1'b1);
    step();
    idle();
    bus.wk_we1 = 1'b1; bus.wk_ent1 = 6'h07; bus.wk_data1 = 32'h11;
    bus.wk_we2 = 1'b1; bus.wk_ent2 = 6'h07; bus.wk_data2 = 32'h22;
    step();
    idle();
    chk("t5_valid", 64'(bus.iss_valid), 64'd1);
    chk("t5_prio",  64'(bus.iss_src1),  64'h11);

    // flush with three busy and a same-cycle dispatch
    dp(6'd31, 32'd1, 1'b1, 32'd1, 1'b1);
    step();
    dp(6'd32, 32'd1, 1'b1, 32'd1, 1'b1);
    step();
    idle();
    chk("t6_cnt3", 64'(bus.count), 64'd3);
    bus.flush = 1'b1;
    dp(6'd33, 32'd1, 1'b1, 32'd1, 1'b1);
    step();
    idle();
    chk("t6_cnt0",   64'(bus.count),     64'd0);
    chk("t6_valid0", 64'(bus.iss_valid), 64'd0);
    chk("t6_full0",  64'(bus.full),      64'd0);

    // async reset while an entry is issuable
    dp(6'd34, 32'h55, 1'b1, 32'h66, 1'b1);
    step();
    idle();
    chk("t7_pre", 64'(bus.iss_valid), 64'd1);
    bus.iss_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_valid", 64'(bus.iss_valid),  64'd0);
    chk("t7_count", 64'(bus.count),      64'd0);
    chk("t7_full",  64'(bus.full),       64'd0);
    chk("t7_src1",  64'(bus.iss_src1),   64'd0);
    chk("t7_tag",   64'(bus.iss_rrftag), 64'd0);
    #2;
    rst_n = 1'b1;
    bus.iss_ready = 1'b0;
    dp(6'd40, 32'h77, 1'b1, 32'h1, 1'b1);
    step();
    idle();
    chk("t7_first_cnt", 64'(bus.count),    64'd1);
    chk("t7_first_src", 64'(bus.iss_src1), 64'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
